// File: rtl/countdown_timer.sv
// BCD seconds countdown timer paced by an external 4 Hz slow clock.
// Runs from a loaded preset down to 00 in quarter-second steps, then blinks the alarm until cleared or reloaded.
module countdown_timer #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk_in,
  input  logic       reset,
  input  logic       slow_clk,
  input  logic [3:0] load_tens,
  input  logic [3:0] load_ones,
  input  logic       load,
  input  logic       start_stop,
  input  logic       clear,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic [1:0] quarter,
  output logic [1:0] state,
  output logic       busy,
  output logic       done,
  output logic       alarm
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  function automatic logic [3:0] clamp_bcd(input logic [3:0] digit);
    clamp_bcd = (digit > 4'd9) ? 4'd9 : digit;
  endfunction

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic [SYNC_STAGES:0]   valid_q;
  logic                   tick_s;

  state_t     state_q, state_d;
  logic [3:0] tens_q, tens_d;
  logic [3:0] ones_q, ones_d;
  logic [1:0] quarter_q, quarter_d;
  logic       alarm_q, alarm_d;
  logic       ss_accept_s;

  // Synchronizer, edge history and a fill marker; the marker keeps the
  // post-reset pipeline fill from looking like a slow_clk rising edge.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      sync_q  <= '0;
      hist_q  <= 1'b0;
      valid_q <= '0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], slow_clk};
      hist_q  <= sync_q[SYNC_STAGES-1];
      valid_q <= {valid_q[SYNC_STAGES-1:0], 1'b1};
    end
  end

  assign tick_s = sync_q[SYNC_STAGES-1] & ~hist_q & valid_q[SYNC_STAGES];

  // State and datapath registers.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      tens_q    <= 4'd0;
      ones_q    <= 4'd0;
      quarter_q <= 2'd0;
      alarm_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      tens_q    <= tens_d;
      ones_q    <= ones_d;
      quarter_q <= quarter_d;
      alarm_q   <= alarm_d;
    end
  end

  // Decide whether start_stop is honoured in the current state.
  always_comb begin
    ss_accept_s = 1'b0;
    case (state_q)
      ST_IDLE:  ss_accept_s = (tens_q != 4'd0) || (ones_q != 4'd0);
      ST_RUN:   ss_accept_s = 1'b1;
      ST_PAUSE: ss_accept_s = 1'b1;
      ST_DONE:  ss_accept_s = 1'b0;
      default:  ss_accept_s = 1'b0;
    endcase
  end

  // Next-state logic; ignored inputs fall through to lower-priority ones.
  always_comb begin
    state_d   = state_q;
    tens_d    = tens_q;
    ones_d    = ones_q;
    quarter_d = quarter_q;
    alarm_d   = alarm_q;
    if (clear) begin
      state_d   = ST_IDLE;
      tens_d    = 4'd0;
      ones_d    = 4'd0;
      quarter_d = 2'd0;
      alarm_d   = 1'b0;
    end else if (load && ((state_q == ST_IDLE) || (state_q == ST_DONE))) begin
      state_d   = ST_IDLE;
      tens_d    = clamp_bcd(load_tens);
      ones_d    = clamp_bcd(load_ones);
      quarter_d = 2'd0;
      alarm_d   = 1'b0;
    end else if (start_stop && ss_accept_s) begin
      // A coincident tick is deliberately dropped here.
      if (state_q == ST_RUN) begin
        state_d = ST_PAUSE;
      end else begin
        state_d = ST_RUN;
      end
    end else if (tick_s) begin
      case (state_q)
        ST_RUN: begin
          if (quarter_q != 2'd3) begin
            quarter_d = quarter_q + 2'd1;
          end else begin
            quarter_d = 2'd0;
            if (ones_q != 4'd0) begin
              ones_d = ones_q - 4'd1;
            end else if (tens_q != 4'd0) begin
              ones_d = 4'd9;
              tens_d = tens_q - 4'd1;
            end else begin
              ones_d = 4'd0;
            end
            if ((tens_d == 4'd0) && (ones_d == 4'd0)) begin
              state_d = ST_DONE;
              alarm_d = 1'b1;
            end else begin
              state_d = ST_RUN;
            end
          end
        end
        ST_DONE: alarm_d = ~alarm_q;
        default: alarm_d = alarm_q;
      endcase
    end else begin
      state_d = state_q;
    end
  end

  assign tens    = tens_q;
  assign ones    = ones_q;
  assign quarter = quarter_q;
  assign state   = state_q;
  assign alarm   = alarm_q;
  assign busy    = (state_q == ST_RUN) || (state_q == ST_PAUSE);
  assign done    = (state_q == ST_DONE);

endmodule

// File: tb/tb_countdown_timer.sv
// Directed self-checking bench for countdown_timer; outputs are sampled on the falling clock edge.
module tb_countdown_timer;

  logic       clk_in = 1'b0;
  logic       reset = 1'b1;
  logic       slow_clk = 1'b0;
  logic [3:0] load_tens = 4'd0;
  logic [3:0] load_ones = 4'd0;
  logic       load = 1'b0;
  logic       start_stop = 1'b0;
  logic       clear = 1'b0;
  logic [3:0] tens, ones;
  logic [1:0] quarter, state;
  logic       busy, done, alarm;

  int total = 0;
  int bad = 0;

  countdown_timer #(.SYNC_STAGES(2)) dut (
    .clk_in(clk_in), .reset(reset), .slow_clk(slow_clk),
    .load_tens(load_tens), .load_ones(load_ones), .load(load),
    .start_stop(start_stop), .clear(clear),
    .tens(tens), .ones(ones), .quarter(quarter), .state(state),
    .busy(busy), .done(done), .alarm(alarm)
  );

  always #10 clk_in = ~clk_in;

  task automatic check_val(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_tick();
    @(negedge clk_in) slow_clk = 1'b1;
    repeat (4) @(negedge clk_in);
    slow_clk = 1'b0;
    repeat (4) @(negedge clk_in);
  endtask

  task automatic do_load(input logic [3:0] t, input logic [3:0] o);
    @(negedge clk_in);
    load_tens = t; load_ones = o; load = 1'b1;
    @(negedge clk_in) load = 1'b0;
  endtask

  task automatic do_ss();
    @(negedge clk_in) start_stop = 1'b1;
    @(negedge clk_in) start_stop = 1'b0;
  endtask

  task automatic do_clear();
    @(negedge clk_in) clear = 1'b1;
    @(negedge clk_in) clear = 1'b0;
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk_in);
    check_val("rst_state", state, 0);
    check_val("rst_count", {tens, ones}, 0);
    check_val("rst_alarm", alarm, 0);
    reset = 1'b0;
    repeat (4) @(negedge clk_in);

    // 12 -> 00 over 48 ticks
    do_load(4'd1, 4'd2);
    check_val("load12", {tens, ones}, 8'h12);
    do_ss();
    check_val("run12_state", state, 1);
    check_val("run12_busy", busy, 1);
    for (int i = 1; i <= 48; i++) begin
      do_tick();
      if (i % 4 == 0) begin
        n = 12 - i / 4;
        check_val($sformatf("cnt_t%0d", i), {tens, ones}, (n / 10) * 16 + (n % 10));
      end
      if (i == 47) begin
        check_val("t47_state", state, 1);
        check_val("t47_quarter", quarter, 3);
      end
    end
    check_val("t48_state", state, 3);
    check_val("t48_done", done, 1);
    check_val("t48_alarm", alarm, 1);
    check_val("t48_busy", busy, 0);

    // alarm blink and clear beating load
    do_tick(); check_val("blink1", alarm, 0);
    do_tick(); check_val("blink2", alarm, 1);
    do_tick(); check_val("blink3", alarm, 0);
    check_val("done_hold", {tens, ones}, 0);
    @(negedge clk_in);
    clear = 1'b1; load = 1'b1; load_tens = 4'd3; load_ones = 4'd4;
    @(negedge clk_in) begin clear = 1'b0; load = 1'b0; end
    check_val("clrld_count", {tens, ones}, 0);
    check_val("clrld_state", state, 0);
    check_val("clrld_alarm", alarm, 0);

    // borrow across digits
    do_load(4'd1, 4'd0);
    do_ss();
    repeat (4) do_tick();
    check_val("borrow_count", {tens, ones}, 8'h09);
    check_val("borrow_quarter", quarter, 0);
    do_clear();
    check_val("clear_state", state, 0);

    // pause preserves quarter; load ignored while paused
    do_load(4'd0, 4'd5);
    do_ss();
    repeat (2) do_tick();
    do_ss();
    check_val("pause_state", state, 2);
    repeat (8) do_tick();
    do_load(4'd9, 4'd9);
    check_val("pause_quarter", quarter, 2);
    check_val("pause_count", {tens, ones}, 8'h05);
    do_ss();
    repeat (2) do_tick();
    check_val("resume_count", {tens, ones}, 8'h04);
    check_val("resume_quarter", quarter, 0);
    check_val("resume_state", state, 1);
    do_clear();

    // clamping and zero start
    do_load(4'hC, 4'hF);
    check_val("clamp", {tens, ones}, 8'h99);
    do_load(4'd0, 4'd0);
    do_ss();
    check_val("zero_start", state, 0);

    // tick latency: update on third edge after slow_clk rises
    do_load(4'd0, 4'd3);
    do_ss();
    @(negedge clk_in) slow_clk = 1'b1;
    @(negedge clk_in) check_val("lat_e1", quarter, 0);
    @(negedge clk_in) check_val("lat_e2", quarter, 0);
    @(negedge clk_in) check_val("lat_e3", quarter, 1);
    repeat (2) @(negedge clk_in);
    slow_clk = 1'b0;
    repeat (4) @(negedge clk_in);

    // tick coincident with start_stop is dropped
    slow_clk = 1'b1;
    repeat (2) @(negedge clk_in);
    start_stop = 1'b1;
    @(negedge clk_in) start_stop = 1'b0;
    check_val("coinc_state", state, 2);
    check_val("coinc_quarter", quarter, 1);
    repeat (2) @(negedge clk_in);
    slow_clk = 1'b0;
    repeat (4) @(negedge clk_in);
    do_clear();

    // reset mid-run with slow_clk held high across release
    do_load(4'd0, 4'd7);
    do_ss();
    do_tick();
    check_val("pre_rst_q", quarter, 1);
    @(negedge clk_in);
    slow_clk = 1'b1;
    reset = 1'b1;
    #1;
    check_val("arst_state", state, 0);
    check_val("arst_count", {tens, ones}, 0);
    check_val("arst_quarter", quarter, 0);
    check_val("arst_flags", {busy, done, alarm}, 0);
    @(negedge clk_in);
    reset = 1'b0;
    load_tens = 4'd0; load_ones = 4'd2; load = 1'b1;
    @(negedge clk_in) begin load = 1'b0; start_stop = 1'b1; end
    @(negedge clk_in) start_stop = 1'b0;
    check_val("rel_state", state, 1);
    repeat (8) @(negedge clk_in);
    check_val("no_false_tick", quarter, 0);
    slow_clk = 1'b0;
    repeat (4) @(negedge clk_in);
    check_val("low_no_tick", quarter, 0);
    do_tick();
    check_val("real_tick", quarter, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
